// File: rtl/my_elements_pkg.sv
// my_elements_pkg -- shared definitions for the serial receiver.
//   deser_state_t : framing state encoding (IDLE / SHIFT / PARITY)
//   cnt_width()   : bit counter width for a WIDTH-bit frame
// Build option: MY_DESER_PARITY_EN (PARITY state only used when defined).
package my_elements_pkg;

  typedef enum logic [1:0] {
    DESER_IDLE   = 2'd0,
    DESER_SHIFT  = 2'd1,
    DESER_PARITY = 2'd2
  } deser_state_t;

  // Counter must be able to hold WIDTH (reached after the last data bit
  // when a parity beat follows), so size it for WIDTH+1 values.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/my_bitcnt.sv
// my_bitcnt -- loadable bit-position counter for the serial receiver.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (count -> 0)
//   load  : load count with 1 (bit 0 of a frame just stored); highest priority
//   clr   : clear count to 0 (frame finished)
//   inc   : increment count
//   count : current bit position
//   last  : count == WIDTH-1 (next stored bit completes the data word)
module my_bitcnt
  import my_elements_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(1);
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/my_deser.sv
// my_deser -- serial-to-parallel receiver, LSB first, start-strobed frames.
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_bit    : serial data bit
//   in_valid  : qualifies in_bit / in_start (a "beat")
//   in_start  : in_bit is bit 0 of a new frame
//   out_data  : last completed word (held between completions)
//   out_valid : one-cycle pulse when out_data updates
//   out_err   : one-cycle pulse on a framing (restart) or parity error
// Build option: define MY_DESER_PARITY_EN to expect an even-parity beat
// after the data bits (frame = WIDTH+1 beats); otherwise frame = WIDTH beats.
module my_deser
  import my_elements_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_err
);

  localparam int CW = cnt_width(WIDTH);

  deser_state_t     state_reg;
  deser_state_t     state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] word_next;
  logic [CW-1:0]    cnt;
  logic             cnt_last;

  // control strobes from the output process
  logic cnt_load;
  logic cnt_clr;
  logic cnt_inc;
  logic sr_first;
  logic sr_store;
  logic done;
  logic restart_err;
  logic par_err;

  my_bitcnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bitcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt),
    .last  (cnt_last)
  );

  // Shift register with the current bit dropped into position cnt.
  // When cnt == WIDTH (parity beat) no position matches, so this is
  // simply the completed data word.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_word
    assign word_next[gi] = (cnt == CW'(gi)) ? in_bit : shift_reg[gi];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= DESER_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DESER_IDLE: begin
        if (in_valid && in_start) state_next = DESER_SHIFT;
      end
      DESER_SHIFT: begin
        if (in_valid && !in_start && cnt_last) begin
`ifdef MY_DESER_PARITY_EN
          state_next = DESER_PARITY;
`else
          state_next = DESER_IDLE;
`endif
        end
      end
`ifdef MY_DESER_PARITY_EN
      DESER_PARITY: begin
        if (in_valid) state_next = in_start ? DESER_SHIFT : DESER_IDLE;
      end
`endif
      default: state_next = DESER_IDLE;
    endcase
  end

  // Output / control logic
  always_comb begin
    cnt_load    = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    sr_first    = 1'b0;
    sr_store    = 1'b0;
    done        = 1'b0;
    restart_err = 1'b0;
    par_err     = 1'b0;
    case (state_reg)
      DESER_IDLE: begin
        // start-less beats in IDLE are silently dropped
        if (in_valid && in_start) begin
          cnt_load = 1'b1;
          sr_first = 1'b1;
        end
      end
      DESER_SHIFT: begin
        if (in_valid) begin
          if (in_start) begin
            // restart: discard partial word, this beat is bit 0
            cnt_load    = 1'b1;
            sr_first    = 1'b1;
            restart_err = 1'b1;
          end else begin
            sr_store = 1'b1;
`ifdef MY_DESER_PARITY_EN
            cnt_inc = 1'b1;
`else
            if (cnt_last) begin
              done    = 1'b1;
              cnt_clr = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
`endif
          end
        end
      end
`ifdef MY_DESER_PARITY_EN
      DESER_PARITY: begin
        if (in_valid) begin
          if (in_start) begin
            cnt_load    = 1'b1;
            sr_first    = 1'b1;
            restart_err = 1'b1;
          end else begin
            done    = 1'b1;
            cnt_clr = 1'b1;
            // even parity: data ones plus parity bit must be even
            par_err = (^shift_reg) ^ in_bit;
          end
        end
      end
`endif
      default: ;
    endcase
  end

  // Datapath and registered output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= done;
      out_err   <= restart_err | par_err;
      if (sr_first) begin
        shift_reg <= WIDTH'(in_bit);
      end else if (sr_store) begin
        shift_reg <= word_next;
      end
      if (done) begin
        out_data <= word_next;
      end
    end
  end

endmodule

// File: tb/tb_my_deser.sv
// tb_my_deser -- table-driven bench for my_deser (WIDTH=8).
// Each table row is one clock: inputs applied, then outputs compared just
// after the rising edge against the hand-derived expectation.
// Build option: MY_DESER_PARITY_EN adds parity beats and parity vectors.
module tb_my_deser;

`ifdef MY_DESER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_start = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       v;
    logic       s;
    logic       b;
    logic       ev;
    logic       ee;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl[$];

  my_deser #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_start  (in_start),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic v, input logic s, input logic b,
                      input logic ev, input logic ee, input logic [7:0] ed);
    vec_t r;
    r.v = v; r.s = s; r.b = b; r.ev = ev; r.ee = ee; r.ed = ed;
    tbl.push_back(r);
  endtask

  // One frame of word w, LSB first, `stalls` idle cycles after each beat.
  // out_data must hold prev until the completing beat, then show w.
  task automatic add_frame(input logic [7:0] w, input int stalls,
                           input logic [7:0] prev, input logic first_err);
    for (int i = 0; i < 8; i++) begin
      logic fin;
      fin = (i == 7) && !PAR;
      push(1'b1, i == 0, w[i], fin, (i == 0) && first_err, fin ? w : prev);
      for (int s = 0; s < stalls; s++) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fin ? w : prev);
    end
    if (PAR) push(1'b1, 1'b0, ^w, 1'b1, 1'b0, w);
  endtask

  task automatic apply(input vec_t r, input string tag);
    in_valid = r.v;
    in_start = r.s;
    in_bit   = r.b;
    @(posedge clk);
    #1;
    chk($sformatf("%s_valid", tag), {31'd0, out_valid}, {31'd0, r.ev});
    chk($sformatf("%s_err", tag), {31'd0, out_err}, {31'd0, r.ee});
    chk($sformatf("%s_data", tag), {24'd0, out_data}, {24'd0, r.ed});
  endtask

  initial begin
    vec_t pre[3];
    logic [7:0] w07;
    w07 = 8'h07;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_err", {31'd0, out_err}, 32'd0);
    chk("reset_data", {24'd0, out_data}, 32'd0);
    rst_n = 1'b1;

    // Three bits of 0xA5 then a mid-frame reset
    pre[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    pre[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    pre[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    for (int i = 0; i < 3; i++) apply(pre[i], $sformatf("pre%0d", i));
    in_valid = 1'b0;
    in_start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_err", {31'd0, out_err}, 32'd0);
    chk("midrst_data", {24'd0, out_data}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Vector table
    add_frame(8'h3C, 0, 8'h00, 1'b0);                 // frame after reset
    push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C);        // start-less beat in IDLE: dropped
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C);
    add_frame(8'hA5, 0, 8'h3C, 1'b0);                 // basic frame
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);        // pulse is one cycle
    add_frame(8'hFF, 0, 8'hA5, 1'b0);                 // back-to-back, no gap
    add_frame(8'h00, 0, 8'hFF, 1'b0);
    add_frame(8'hA5, 2, 8'h00, 1'b0);                 // stalls between beats
    // restart: 5 bits, then a start beat opening a full 0x81 frame
    push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
    push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);
    add_frame(8'h81, 0, 8'hA5, 1'b1);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81);
`ifdef MY_DESER_PARITY_EN
    // 0x07 with correct parity 1
    for (int i = 0; i < 8; i++) push(1'b1, i == 0, w07[i], 1'b0, 1'b0, 8'h81);
    push(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h07);
    // 0x07 with wrong parity 0 after a different word, so data visibly loads
    add_frame(8'h3C, 0, 8'h07, 1'b0);
    for (int i = 0; i < 8; i++) push(1'b1, i == 0, w07[i], 1'b0, 1'b0, 8'h3C);
    push(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07);
    // start on the parity beat: restart error, that beat is bit 0 of 0x07
    for (int i = 0; i < 8; i++) push(1'b1, i == 0, 1'b0, 1'b0, 1'b0, 8'h07);
    push(1'b1, 1'b1, w07[0], 1'b0, 1'b1, 8'h07);
    for (int i = 1; i < 8; i++) push(1'b1, 1'b0, w07[i], 1'b0, 1'b0, 8'h07);
    push(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h07);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07);
`endif

    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    // Asynchronous reset clears a nonzero out_data without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_data", {24'd0, out_data}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
